// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Two-requester front end for a single UART transmitter. Each
//            requester pushes words into its own FIFO. A round-robin
//            arbiter then launches one word at a time into the transmitter
//            with a one-cycle strobe. It waits out the transmitter's busy
//            period before it launches the next word.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PAYLOAD_BITS : width of one UART word
//   FIFO_DEPTH   : entries per requester FIFO (power of two, >= 2)
// Ports
//   clk          : system clock, rising edge
//   resetn       : asynchronous active-low reset
//   req0_valid/req0_data/req0_ready : requester-0 push handshake
//   req1_valid/req1_data/req1_ready : requester-1 push handshake
//   uart_tx_en   : one-cycle transmit strobe
//   uart_tx_data : word to transmit; holds its value until the next grant
//   uart_tx_busy : transmitter busy flag (rises one cycle after the strobe)
//   fifo0_count  : occupancy of requester-0 FIFO
//   fifo1_count  : occupancy of requester-1 FIFO
//   grant_id     : requester that owns the most recently launched word
// ============================================================================
module uart_tx_arbiter #(
   parameter int PAYLOAD_BITS = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          req0_valid,
   input  logic [PAYLOAD_BITS-1:0]       req0_data,
   output logic                          req0_ready,
   input  logic                          req1_valid,
   input  logic [PAYLOAD_BITS-1:0]       req1_data,
   output logic                          req1_ready,
   output logic                          uart_tx_en,
   output logic [PAYLOAD_BITS-1:0]       uart_tx_data,
   input  logic                          uart_tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo0_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo1_count,
   output logic                          grant_id
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   // FSM encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_GUARD  = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

   // Per-requester views, indexed by requester number
   logic [1:0]                         push_valid;
   logic [1:0][PAYLOAD_BITS-1:0]       push_data;
   logic [1:0]                         push_ready;
   logic [1:0]                         push_fire;
   logic [1:0]                         pop;
   logic [1:0]                         not_empty;
   logic [1:0][PAYLOAD_BITS-1:0]       head_data;
   logic [1:0][CNT_W-1:0]              count;

   // Arbiter / FSM state
   logic [1:0]                         state;
   logic                               last_grant;
   logic                               grant_go;
   logic                               winner;

   assign push_valid   = {req1_valid, req0_valid};
   assign push_data[0] = req0_data;
   assign push_data[1] = req1_data;

   assign req0_ready   = push_ready[0];
   assign req1_ready   = push_ready[1];
   assign fifo0_count  = count[0];
   assign fifo1_count  = count[1];

   // -------------------------------------------------------------------------
   // Requester FIFOs
   // -------------------------------------------------------------------------
   for (genvar g = 0; g < 2; g++) begin : g_fifo
      logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]        wr_ptr;
      logic [PTR_W-1:0]        rd_ptr;
      logic [CNT_W-1:0]        cnt;

      // Ready comes from the registered count only. A full FIFO therefore
      // refuses a push even on the same edge that it pops.
      assign push_ready[g] = (cnt < DEPTH_C);
      assign push_fire[g]  = push_valid[g] & push_ready[g];
      assign not_empty[g]  = (cnt != '0);
      assign head_data[g]  = mem[rd_ptr];
      assign count[g]      = cnt;

      // Storage needs no reset. Occupancy is tracked by cnt and the pointers.
      always_ff @(posedge clk) begin
         if (push_fire[g]) begin
            mem[wr_ptr] <= push_data[g];
         end
      end

      // The pointers are exactly PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push_fire[g]) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop[g]) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire[g], pop[g]})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
         end
      end
   end

   // -------------------------------------------------------------------------
   // Round-robin winner selection and pop generation
   // -------------------------------------------------------------------------
   always_comb begin
      grant_go = (state == ST_IDLE) && (|not_empty) && !uart_tx_busy;
      // When both FIFOs have data, the requester that was not granted last
      // wins. Otherwise the only non-empty FIFO wins.
      if (&not_empty) begin
         winner = ~last_grant;
      end else begin
         winner = not_empty[1];
      end
      pop = 2'b00;
      if (grant_go) begin
         pop = winner ? 2'b10 : 2'b01;
      end
   end

   // -------------------------------------------------------------------------
   // Launch FSM
   //   IDLE   : wait for data and an idle transmitter, then grant and pop
   //   LAUNCH : uart_tx_en high for exactly this cycle
   //   GUARD  : busy is not valid yet (it rises a cycle after the strobe)
   //   WAIT   : hold until the transmitter drops busy
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         uart_tx_en   <= 1'b0;
         uart_tx_data <= '0;
         grant_id     <= 1'b0;
         last_grant   <= 1'b1;   // requester 0 wins the first tie
      end else begin
         uart_tx_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_go) begin
                  state        <= ST_LAUNCH;
                  uart_tx_en   <= 1'b1;
                  uart_tx_data <= head_data[winner];
                  grant_id     <= winner;
                  last_grant   <= winner;
               end
            end
            ST_LAUNCH: begin
               state <= ST_GUARD;
            end
            ST_GUARD: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!uart_tx_busy) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. Directed stimulus
//            pushes hand-computed launch expectations into a scoreboard.
//            A monitor pops one entry for every strobe the DUT issues and
//            compares it. A small transmitter model raises busy one cycle
//            after each strobe, for busy_len cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int PB = 8;
   localparam int FD = 4;

   logic          clk        = 1'b0;
   logic          resetn     = 1'b1;
   logic          req0_valid = 1'b0;
   logic [PB-1:0] req0_data  = '0;
   logic          req0_ready;
   logic          req1_valid = 1'b0;
   logic [PB-1:0] req1_data  = '0;
   logic          req1_ready;
   logic          uart_tx_en;
   logic [PB-1:0] uart_tx_data;
   logic          uart_tx_busy;
   logic [2:0]    fifo0_count;
   logic [2:0]    fifo1_count;
   logic          grant_id;

   uart_tx_arbiter #(.PAYLOAD_BITS(PB), .FIFO_DEPTH(FD)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req0_valid   (req0_valid),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .uart_tx_busy (uart_tx_busy),
      .fifo0_count  (fifo0_count),
      .fifo1_count  (fifo1_count),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- transmitter model ----------------
   logic busy_force = 1'b0;
   int   busy_len   = 3;
   int   model_cnt  = 0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn)             model_cnt <= 0;
      else if (uart_tx_en)     model_cnt <= busy_len;
      else if (model_cnt != 0) model_cnt <= model_cnt - 1;
   end
   assign uart_tx_busy = busy_force | (model_cnt != 0);

   // ---------------- scoreboard ----------------
   typedef struct {
      logic          gid;
      logic [PB-1:0] data;
      int            at_cyc;   // -1 : launch cycle not checked
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic busy_at_edge = 1'b0;
   int   last_strobe  = 0;
   int   prev_strobe  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic gid, input logic [PB-1:0] d, input int at);
      exp_t e;
      e.gid    = gid;
      e.data   = d;
      e.at_cyc = at;
      sb_q.push_back(e);
   endtask

   // This holds the busy value seen at the edge that made the grant.
   always @(posedge clk) busy_at_edge <= uart_tx_busy;

   always @(negedge clk) begin
      if (resetn && uart_tx_en) begin
         prev_strobe = last_strobe;
         last_strobe = cyc;
         if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_strobe: got data 0x%0h grant %0d, expected no strobe",
                     uart_tx_data, grant_id);
         end else begin
            mon_e = sb_q.pop_front();
            check("strobe_data", 32'(uart_tx_data), 32'(mon_e.data));
            check("strobe_grant", 32'(grant_id), 32'(mon_e.gid));
            check("strobe_while_busy", 32'(busy_at_edge), 32'd0);
            if (mon_e.at_cyc >= 0) check("strobe_latency", cyc, mon_e.at_cyc);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input int r, input logic [PB-1:0] d, input bit exp_acc,
                       input bit drop_busy, output int edge_cyc);
      logic rdy;
      @(negedge clk);
      if (drop_busy) busy_force = 1'b0;
      if (r == 0) begin
         req0_valid = 1'b1; req0_data = d; rdy = req0_ready;
      end else begin
         req1_valid = 1'b1; req1_data = d; rdy = req1_ready;
      end
      check($sformatf("push_ready_r%0d_%02h", r, d), 32'(rdy), 32'(exp_acc));
      @(posedge clk);
      #1;
      edge_cyc   = cyc;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input bit need_idle);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || (need_idle && uart_tx_busy)) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s_drain_timeout", name), 32'(n >= 1000), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int e;

      // Reset state. The reset is applied between clock edges, so its
      // effect has to appear at once, without waiting for an edge.
      #1 resetn = 1'b0;
      #1;
      check("rst_tx_en",   32'(uart_tx_en),   32'd0);
      check("rst_tx_data", 32'(uart_tx_data), 32'd0);
      check("rst_grant",   32'(grant_id),     32'd0);
      check("rst_cnt0",    32'(fifo0_count),  32'd0);
      check("rst_cnt1",    32'(fifo1_count),  32'd0);
      check("rst_ready0",  32'(req0_ready),   32'd1);
      check("rst_ready1",  32'(req1_ready),   32'd1);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Fairness: requester 0 wins the first tie, then the grants alternate.
      busy_force = 1'b1;
      busy_len   = 10;
      push(0, 8'h10, 1, 0, e);
      push(0, 8'h11, 1, 0, e);
      push(1, 8'h20, 1, 0, e);
      push(1, 8'h21, 1, 0, e);
      check("fair_cnt0", 32'(fifo0_count), 32'd2);
      check("fair_cnt1", 32'(fifo1_count), 32'd2);
      expect_word(0, 8'h10, -1);
      expect_word(1, 8'h20, -1);
      expect_word(0, 8'h11, -1);
      expect_word(1, 8'h21, -1);
      @(negedge clk) busy_force = 1'b0;
      wait_drain("fair", 1);

      // Single word: the strobe comes in the cycle after edge E+1.
      busy_len = 3;
      push(0, 8'h41, 1, 0, e);
      expect_word(0, 8'h41, e + 1);
      wait_drain("single", 1);
      check("hold_data",  32'(uart_tx_data), 32'h41);
      check("hold_grant", 32'(grant_id),     32'd0);

      // Full FIFO on requester 1
      busy_force = 1'b1;
      for (int i = 0; i < 4; i++) push(1, 8'(8'h30 + i), 1, 0, e);
      check("full_cnt1",   32'(fifo1_count), 32'd4);
      check("full_ready1", 32'(req1_ready),  32'd0);
      push(1, 8'h34, 0, 0, e);
      check("full_cnt1_after", 32'(fifo1_count), 32'd4);
      for (int i = 0; i < 4; i++) expect_word(1, 8'(8'h30 + i), -1);
      @(negedge clk) busy_force = 1'b0;
      wait_drain("full", 1);

      // Concurrent push/pop with a full FIFO: the push is refused.
      busy_force = 1'b1;
      for (int i = 0; i < 4; i++) push(0, 8'(8'h50 + i), 1, 0, e);
      for (int i = 0; i < 4; i++) expect_word(0, 8'(8'h50 + i), -1);
      push(0, 8'h54, 0, 1, e);   // the same edge pops 0x50
      check("cc_full_cnt0", 32'(fifo0_count), 32'd3);
      wait_drain("cc_full", 1);

      // Concurrent push/pop with a count of 2: the count stays 2 and the
      // order is kept across the pointer wrap.
      busy_force = 1'b1;
      push(0, 8'h60, 1, 0, e);
      push(0, 8'h61, 1, 0, e);
      expect_word(0, 8'h60, -1);
      expect_word(0, 8'h61, -1);
      expect_word(0, 8'h62, -1);
      push(0, 8'h62, 1, 1, e);   // the same edge pops 0x60
      check("cc_two_cnt0", 32'(fifo0_count), 32'd2);
      wait_drain("cc_two", 1);

      // Busy latency: busy is high only during GUARD. Each word gets one
      // strobe, and consecutive launches are LAUNCH,GUARD,WAIT,IDLE apart.
      // The last grant went to requester 0, so requester 1 wins the tie.
      busy_force = 1'b1;
      busy_len   = 1;
      push(0, 8'h70, 1, 0, e);
      push(1, 8'h71, 1, 0, e);
      expect_word(1, 8'h71, -1);
      expect_word(0, 8'h70, -1);
      @(negedge clk) busy_force = 1'b0;
      wait_drain("blat", 1);
      check("blat_spacing", last_strobe - prev_strobe, 32'd4);

      // Reset mid-frame, with 3 words still queued while in WAIT
      busy_force = 1'b1;
      busy_len   = 20;
      push(0, 8'h80, 1, 0, e);
      push(0, 8'h81, 1, 0, e);
      push(1, 8'h90, 1, 0, e);
      push(1, 8'h91, 1, 0, e);
      expect_word(1, 8'h90, -1);
      @(negedge clk) busy_force = 1'b0;
      wait_drain("mid_launch", 0);
      check("mid_queued", 32'(fifo0_count) + 32'(fifo1_count), 32'd3);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_tx_en", 32'(uart_tx_en),  32'd0);
      check("mid_rst_cnt0",  32'(fifo0_count), 32'd0);
      check("mid_rst_cnt1",  32'(fifo1_count), 32'd0);
      check("mid_rst_ready", 32'({req1_ready, req0_ready}), 32'd3);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (20) @(negedge clk);   // no strobe is expected here
      check("mid_post_cnt", 32'(fifo0_count) + 32'(fifo1_count), 32'd0);
      busy_len = 3;
      push(0, 8'hA0, 1, 0, e);
      expect_word(0, 8'hA0, e + 1);
      wait_drain("mid_new", 1);

      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
